// File: rtl/cnn_pkg.sv
// Shared constants and loader state encoding for the CNN kernel-weight path.
// Imported by the loader, its row buffer and the stream interface users.
package cnn_pkg;

    localparam int K      = 5;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } ld_state_e;

endpackage

// File: rtl/kernel_weight_loader_if.sv
// Valid/ready weight stream feeding the kernel weight loader.
// The producer drives valid/data; the loader drives ready.
interface kernel_weight_loader_if #(
    parameter int DATA_W = cnn_pkg::DATA_W
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/kernel_weight_loader_row_buffer.sv
// One kernel row of weights, written a column at a time and read in parallel.
// Clear has priority over a column write.
module kernel_row_buffer #(
    parameter int K      = cnn_pkg::K,
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int CW     = $clog2(K)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       we_i,
    input  logic [CW-1:0]              idx_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [K-1:0][DATA_W-1:0]   row_o
);

    logic [K-1:0][DATA_W-1:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (clr_i) begin
            row_q <= '0;
        end else if (we_i) begin
            for (int c = 0; c < K; c++) begin
                if (idx_i == CW'(c)) begin
                    row_q[c] <= data_i;
                end
            end
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/kernel_weight_loader.sv
// Gathers a row-major 5x5 weight stream into rows and writes each row
// across the 5-RAM kernel bank in a single cycle.
module kernel_weight_loader #(
    parameter int DATA_W    = cnn_pkg::DATA_W,
    parameter int K         = cnn_pkg::K,
    parameter int ADDR_W    = cnn_pkg::ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    kernel_weight_loader_if.slave s,
    output logic [ADDR_W-1:0]     addr_write,
    output logic [K-1:0]          write_enable,
    output logic [DATA_W-1:0]     wr_data_0,
    output logic [DATA_W-1:0]     wr_data_1,
    output logic [DATA_W-1:0]     wr_data_2,
    output logic [DATA_W-1:0]     wr_data_3,
    output logic [DATA_W-1:0]     wr_data_4,
    output logic                  busy,
    output logic                  done
);

    import cnn_pkg::*;

    localparam int            CW   = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K-1);

    ld_state_e                state_q, state_d;
    logic [CW-1:0]            col_q, col_d;
    logic [CW-1:0]            row_q, row_d;
    logic                     s_ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic [K-1:0]             we_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [K-1:0][DATA_W-1:0] wd_q, wd_d;
    logic [K-1:0][DATA_W-1:0] buf_row;
    logic                     buf_we;
    logic                     buf_clr;
    logic                     take;

    kernel_row_buffer #(
        .K      (K),
        .DATA_W (DATA_W),
        .CW     (CW)
    ) u_row_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (buf_clr),
        .we_i   (buf_we),
        .idx_i  (col_q),
        .data_i (s.s_data),
        .row_o  (buf_row)
    );

    assign take = (state_q == LOAD) && s.s_valid && s_ready_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        buf_we  = 1'b0;
        buf_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    col_d   = '0;
                    row_d   = '0;
                    buf_clr = 1'b1;
                end
            end
            LOAD: begin
                if (take) begin
                    buf_we = 1'b1;
                    if (col_q == LAST) begin
                        col_d   = '0;
                        state_d = WRITE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (row_q == LAST) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort beats every transition, including a start seen in IDLE.
        if (abort) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
            buf_we  = 1'b0;
            buf_clr = 1'b0;
        end
    end

    // The last column arrives on the edge that enters WRITE, so bypass it.
    always_comb begin
        for (int c = 0; c < K; c++) begin
            wd_d[c] = (col_q == CW'(c)) ? s.s_data : buf_row[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            s_ready_q <= (state_d == LOAD);
            busy_q    <= (state_d == LOAD) || (state_d == WRITE);
            done_q    <= (state_d == DONE);
            we_q      <= {K{state_d == WRITE}};
            if (state_d == WRITE) begin
                addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(row_q);
                wd_q   <= wd_d;
            end
        end
    end

    assign s.s_ready    = s_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign write_enable = we_q;
    assign addr_write   = addr_q;
    assign wr_data_0    = wd_q[0];
    assign wr_data_1    = wd_q[1];
    assign wr_data_2    = wd_q[2];
    assign wr_data_3    = wd_q[3];
    assign wr_data_4    = wd_q[4];

endmodule

// File: tb/tb_kernel_weight_loader.sv
// Directed bench for kernel_weight_loader with a row/bank scoreboard model.
// Expected rows come from the accepted stream words; bank contents from 5r+c.
module tb_kernel_weight_loader;

    import cnn_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] addr_write;
    logic [K-1:0]      write_enable;
    logic [DATA_W-1:0] wr_d [K];
    logic              busy;
    logic              done;

    kernel_weight_loader_if #(.DATA_W(DATA_W)) sif ();

    kernel_weight_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .s            (sif.slave),
        .addr_write   (addr_write),
        .write_enable (write_enable),
        .wr_data_0    (wr_d[0]),
        .wr_data_1    (wr_d[1]),
        .wr_data_2    (wr_d[2]),
        .wr_data_3    (wr_d[3]),
        .wr_data_4    (wr_d[4]),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] row_m [$];
    logic [DATA_W-1:0] bank [8][K];
    int row_idx = 0;
    int n_writes = 0;
    int n_dones = 0;
    int load_cyc = 0;
    int first_wr_cyc = -1;
    int done_cyc = -1;
    logic busy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, got, exp, cyc);
        end
    endtask

    // Scoreboard: rows are rebuilt from the words the handshake accepted.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                row_m.delete();
                row_idx   = 0;
                busy_prev = 1'b0;
            end else begin
                if (busy && !busy_prev) begin
                    load_cyc     = cyc;
                    first_wr_cyc = -1;
                    done_cyc     = -1;
                    for (int a = 0; a < 8; a++)
                        for (int c = 0; c < K; c++)
                            bank[a][c] = 16'hdead;
                end
                busy_prev = busy;
                if (write_enable != '0) begin
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    chk("we_mask", 32'(write_enable), 32'h1f);
                    chk("wr_addr", 32'(addr_write), 32'(row_idx));
                    chk("row_fill", 32'(row_m.size()), 32'(K));
                    for (int c = 0; c < K; c++) begin
                        chk("wr_data", 32'(wr_d[c]),
                            (c < row_m.size()) ? 32'(row_m[c]) : 32'hffff_ffff);
                        bank[addr_write][c] = wr_d[c];
                    end
                    row_m.delete();
                    row_idx++;
                    n_writes++;
                end
                if (done) begin
                    chk("done_rows", 32'(row_idx), 32'(K));
                    n_dones++;
                    done_cyc = cyc;
                    row_idx  = 0;
                end
                if (sif.s_valid && sif.s_ready) begin
                    chk("row_room", 32'(row_m.size() < K), 32'd1);
                    row_m.push_back(sif.s_data);
                end
                if (abort) begin
                    row_m.delete();
                    row_idx = 0;
                end
            end
        end
    endtask

    task automatic stream(input int n, input int stall_pct,
                          input int abort_at, input int start_at);
        int   idx = 0;
        int   guard = 0;
        logic hs;
        while (idx < n && guard < 2000) begin
            guard++;
            if (idx == abort_at) begin
                abort       = 1'b1;
                sif.s_valid = 1'b0;
                @(posedge clk);
                #1 abort = 1'b0;
                return;
            end
            start       = (idx == start_at);
            sif.s_valid = ($urandom_range(99) >= stall_pct);
            sif.s_data  = DATA_W'(idx);
            @(negedge clk);
            hs = sif.s_valid && sif.s_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
        end
        start       = 1'b0;
        sif.s_valid = 1'b0;
        chk("stream_words", 32'(idx), 32'(n));
    endtask

    task automatic check_bank(input int rows);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                chk(r < rows ? "bank_row" : "bank_untouched", 32'(bank[r][c]),
                    r < rows ? 32'(5 * r + c) : 32'hdead);
    endtask

    task automatic run_load(input int stall, input int abort_at,
                            input int start_at, input int exp_rows,
                            input bit timed);
        int w0 = n_writes;
        int d0 = n_dones;
        int g = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stream(K * K, stall, abort_at, start_at);
        if (exp_rows == K) begin
            while (n_dones == d0 && g < 100) begin
                @(negedge clk);
                g++;
            end
        end else begin
            repeat (10) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("writes", 32'(n_writes - w0), 32'(exp_rows));
        chk("dones", 32'(n_dones - d0), 32'(exp_rows == K));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(sif.s_ready), 32'd0);
        if (timed) begin
            chk("first_wr_lat", 32'(first_wr_cyc - load_cyc), 32'd5);
            chk("done_lat", 32'(done_cyc - load_cyc), 32'd30);
        end
        check_bank(exp_rows);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(sif.s_ready), 32'd0);
        chk({tag, "_we"}, 32'(write_enable), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_addr"}, 32'(addr_write), 32'd0);
        for (int c = 0; c < K; c++)
            chk({tag, "_wdata"}, 32'(wr_d[c]), 32'd0);
    endtask

    initial begin
        int g;
        logic [K-1:0] we_seen;
        sif.s_valid = 1'b1;
        sif.s_data  = 16'h1234;
        start       = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        start       = 1'b0;
        sif.s_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_rst");

        run_load(0, -1, -1, K, 1'b1);
        chk("pin_r2c3", 32'(bank[2][3]), 32'd13);
        chk("pin_r4c4", 32'(bank[4][4]), 32'd24);

        run_load(40, -1, -1, K, 1'b0);
        run_load(0, 12, -1, 2, 1'b0);
        run_load(0, -1, -1, K, 1'b1);
        run_load(0, -1, 7, K, 1'b1);

        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stream(K, 0, -1, -1);
        g = 0;
        while (write_enable == '0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        we_seen = write_enable;
        chk("mid_write_we", 32'(we_seen), 32'h1f);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("after_async");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
